mc_scoreboard: RTL
==================

# mc_scoreboard

Issue-stage hazard controller for the RISC-V core's multi-cycle units (divider, FPU). It keeps a per-register scoreboard of outstanding multi-cycle writes for the integer file and, when FLOAT=1, the float file. It stalls ID on RAW, WAW, load-use and structural hazards that the single-cycle MEM/WB forwarding path cannot cover. It also owns a one-entry completion buffer that shares the register-file write port with the main pipeline writeback.

## Interface
- FLOAT, 0, 1 enables the float scoreboard and the file-select inputs; 0 treats every float_* input as 0
- MAX_PEND, 4, maximum outstanding multi-cycle writes (1..31)
- STARVE_LIM, 8, cycles a buffered result may wait for the write port before a forced stall
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- rs1id, rs2id, rdid  in  5  ID source and destination indices
- float_read  in  2  [1] rs1 is float, [0] rs2 is float
- float_write  in  1  rd is float
- id_wb  in  1  ID instruction writes rd
- id_mc  in  1  ID instruction dispatches to a multi-cycle unit
- rdex  in  5, memread_ex  in  1, float_ex  in  1  EX-stage load destination
- mc_busy  in  1  multi-cycle unit cannot accept
- mc_done  in  1, mc_rd  in  5, mc_float  in  1  completion from the unit
- wb_pipe  in  1  main pipeline uses the RF write port this cycle
- stall  out  1  hold IF/ID, bubble into EX
- mc_issue  out  1  dispatch accepted
- mc_ack  out  1  completion captured
- mc_wb_en  out  1, mc_wb_rd  out  5, mc_wb_float  out  1  buffered result writes the RF
- pending_cnt  out  6  outstanding multi-cycle writes

## Operation
- The scoreboard has two files:
  - pend_int[31:0] and pend_fp[31:0]. pend_fp is held at 0 when FLOAT=0.
  - Integer x0 is never pending and never hazards. Float f0 is a normal register.
- Hazard terms. All use the registered scoreboard state, never same-cycle updates.
  - raw: rs1id is pending in the file selected by float_read[1], or rs2id is pending in the file selected by float_read[0].
  - waw: id_wb and rdid is pending in the file selected by float_write.
  - loaduse: memread_ex, rdex matches rs1id or rs2id, the file matches (float_ex equals the corresponding float_read bit), and the index is not integer x0.
  - struct: id_mc and (mc_busy, or pending_cnt == MAX_PEND, or the buffer is valid with age ≥ STARVE_LIM).
  - starve: the buffer is valid and age ≥ STARVE_LIM.
- stall = id_valid && (raw || waw || loaduse || struct || starve).
- mc_issue = id_valid && id_mc && !stall.
  - It sets the pend bit for rdid in its file, unless the destination is integer x0.
  - It increments pending_cnt when a bit is actually set.
- Completion buffer (buf_v, buf_rd, buf_float, age):
  - mc_wb_en = buf_v && !wb_pipe. The pipeline always has port priority.
  - mc_ack = mc_done && (!buf_v || mc_wb_en). The unit must hold mc_done and its operands until acked.
  - On mc_ack, the buffer loads mc_rd/mc_float and age resets to 0.
  - On mc_wb_en without mc_ack, buf_v clears.
  - While buf_v && !mc_wb_en, age increments and saturates at STARVE_LIM.
- mc_wb_en clears the pend bit of buf_rd/buf_float and decrements pending_cnt.
- Issue and writeback in the same cycle leave pending_cnt unchanged.
- A set and a clear of the same bit in the same cycle cannot occur: the WAW/RAW stall is computed from the pre-clear state.
- A completion whose rd is not pending (integer x0) still writes through the buffer. It causes no clear and no decrement.

## Timing
- Reset: pend_int, pend_fp, buf_v, age and pending_cnt are 0. stall, mc_issue, mc_ack and mc_wb_en are 0 whenever id_valid, mc_done and buf_v are 0. mc_wb_rd/mc_wb_float read 0.
- stall, mc_issue, mc_ack and mc_wb_en are combinational from the inputs and registered state.
- Scoreboard, buffer and counter update on the rising edge.
- mc_done to mc_wb_en takes at least 1 cycle (buffer register). It takes longer while wb_pipe is high.
- A pend bit clears on the edge that ends the mc_wb_en cycle. A dependent instruction issues at the earliest in the following cycle and reads the RF, with no forwarding needed.
- Starvation: age reaches STARVE_LIM and stall rises. Bubbles reach WB in pipeline depth cycles, wb_pipe drops, and the buffer drains.
- rst asserted mid-operation clears everything on the next edge. In-flight unit results are discarded by the unit's own reset.

## Test plan
- Reset, then idle: all outputs 0 and pending_cnt = 0.
- Issue div to x5, then `add x6,x5,x1`: stall = 1 until mc_done/mc_wb_en for x5. The add issues the cycle after mc_wb_en, and pending_cnt goes 1 → 0.
- FLOAT=1, FPU write to f3 pending; ID reads integer x3 (float_read = 00) → no stall. ID reads f3 (float_read[1] = 1) → stall.
- Load to x7 in EX (memread_ex = 1, rdex = 7); ID uses x7 as rs2 → stall for exactly 1 cycle. The same with rdex = 0 → no stall.
- MAX_PEND = 4 outstanding; fifth id_mc → stall and mc_issue = 0. One writeback → issue proceeds the next cycle.
- mc_done while wb_pipe = 1 continuously:
  - Buffer holds and mc_wb_en = 0.
  - A second mc_done is not acked.
  - After 8 cycles stall = 1. Drop wb_pipe → mc_wb_en = 1 and the second completion is acked in the same cycle.

Source files
------------

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: issue-stage hazard control for multi-cycle units (divider, FPU).
// Tracks outstanding multi-cycle writes per register and owns a one-entry
// completion buffer that shares the register-file write port with writeback.
module mc_scoreboard #(
   parameter int unsigned FLOAT      = 0,
   parameter int unsigned MAX_PEND   = 4,
   parameter int unsigned STARVE_LIM = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] rs1id,
   input  logic [4:0] rs2id,
   input  logic [4:0] rdid,
   input  logic [1:0] float_read,
   input  logic       float_write,
   input  logic       id_wb,
   input  logic       id_mc,
   input  logic [4:0] rdex,
   input  logic       memread_ex,
   input  logic       float_ex,
   input  logic       mc_busy,
   input  logic       mc_done,
   input  logic [4:0] mc_rd,
   input  logic       mc_float,
   input  logic       wb_pipe,
   output logic       stall,
   output logic       mc_issue,
   output logic       mc_ack,
   output logic       mc_wb_en,
   output logic [4:0] mc_wb_rd,
   output logic       mc_wb_float,
   output logic [5:0] pending_cnt
);

   localparam int unsigned     AGE_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);
   localparam logic [5:0]       CNT_MAX = 6'(MAX_PEND);
   localparam logic             FP_EN   = (FLOAT != 0);

   logic [31:0]      pend_int_q, pend_int_d;
   logic [31:0]      pend_fp_q, pend_fp_d;
   logic             buf_v_q, buf_v_d;
   logic [4:0]       buf_rd_q, buf_rd_d;
   logic             buf_float_q, buf_float_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic [5:0]       cnt_q, cnt_d;

   logic [1:0] fr;
   logic       fw, fex, mcf;
   logic       rs1_pend, rs2_pend, rd_pend, buf_pend;
   logic       raw, waw, lu_rs1, lu_rs2, loaduse, starve, struct_h;
   logic       do_set, do_clr;

   // Float selects collapse to the integer file when the float scoreboard is absent
   assign fr  = FP_EN ? float_read : 2'b00;
   assign fw  = FP_EN ? float_write : 1'b0;
   assign fex = FP_EN ? float_ex : 1'b0;
   assign mcf = FP_EN ? mc_float : 1'b0;

   // Lookups use registered state only; pend_int_q[0] is forced low so x0 never hazards
   assign rs1_pend = fr[1] ? pend_fp_q[rs1id] : pend_int_q[rs1id];
   assign rs2_pend = fr[0] ? pend_fp_q[rs2id] : pend_int_q[rs2id];
   assign rd_pend  = fw ? pend_fp_q[rdid] : pend_int_q[rdid];
   assign buf_pend = buf_float_q ? pend_fp_q[buf_rd_q] : pend_int_q[buf_rd_q];

   assign raw      = rs1_pend || rs2_pend;
   assign waw      = id_wb && rd_pend;
   assign lu_rs1   = (rdex == rs1id) && (fex == fr[1]) && (fex || (rdex != 5'd0));
   assign lu_rs2   = (rdex == rs2id) && (fex == fr[0]) && (fex || (rdex != 5'd0));
   assign loaduse  = memread_ex && (lu_rs1 || lu_rs2);
   assign starve   = buf_v_q && (age_q >= AGE_LIM);
   assign struct_h = id_mc && (mc_busy || (cnt_q >= CNT_MAX) || starve);

   assign stall    = id_valid && (raw || waw || loaduse || struct_h || starve);
   assign mc_issue = id_valid && id_mc && !stall;
   assign mc_wb_en = buf_v_q && !wb_pipe;
   assign mc_ack   = mc_done && (!buf_v_q || mc_wb_en);

   assign mc_wb_rd    = buf_rd_q;
   assign mc_wb_float = buf_float_q;
   assign pending_cnt = cnt_q;

   // A set only counts when the bit was clear, and a clear only when it was set,
   // so the counter always equals the population of both files.
   assign do_clr = mc_wb_en && buf_pend;
   assign do_set = mc_issue && (fw || (rdid != 5'd0)) && !rd_pend;

   // Next state for scoreboard, counter and completion buffer
   always_comb begin
      pend_int_d  = pend_int_q;
      pend_fp_d   = pend_fp_q;
      cnt_d       = cnt_q;
      buf_v_d     = buf_v_q;
      buf_rd_d    = buf_rd_q;
      buf_float_d = buf_float_q;
      age_d       = age_q;

      if (do_clr) begin
         if (buf_float_q) pend_fp_d[buf_rd_q] = 1'b0;
         else             pend_int_d[buf_rd_q] = 1'b0;
      end
      if (do_set) begin
         if (fw) pend_fp_d[rdid] = 1'b1;
         else    pend_int_d[rdid] = 1'b1;
      end
      case ({do_set, do_clr})
         2'b10:   cnt_d = cnt_q + 6'd1;
         2'b01:   cnt_d = cnt_q - 6'd1;
         default: cnt_d = cnt_q;
      endcase
      if (!FP_EN) pend_fp_d = '0;
      pend_int_d[0] = 1'b0;

      if (mc_ack) begin
         buf_v_d     = 1'b1;
         buf_rd_d    = mc_rd;
         buf_float_d = mcf;
         age_d       = '0;
      end else if (mc_wb_en) begin
         buf_v_d = 1'b0;
         age_d   = '0;
      end else if (buf_v_q && (age_q < AGE_LIM)) begin
         age_d = age_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_int_q  <= '0;
         pend_fp_q   <= '0;
         cnt_q       <= '0;
         buf_v_q     <= 1'b0;
         buf_rd_q    <= '0;
         buf_float_q <= 1'b0;
         age_q       <= '0;
      end else begin
         pend_int_q  <= pend_int_d;
         pend_fp_q   <= pend_fp_d;
         cnt_q       <= cnt_d;
         buf_v_q     <= buf_v_d;
         buf_rd_q    <= buf_rd_d;
         buf_float_q <= buf_float_d;
         age_q       <= age_d;
      end
   end

endmodule
